// File: rtl/fifo_pkt_reader_if.sv
// Bundle of the FIFO read port and the downstream byte stream.
// master = packet reader, slave = FIFO/sink side.
interface fifo_pkt_reader_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  R_INC;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  OUT_SOP;
    logic                  OUT_EOP;

    modport master (
        input  EMPTY, RD_DATA, OUT_READY,
        output R_INC, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP
    );

    modport slave (
        output EMPTY, RD_DATA, OUT_READY,
        input  R_INC, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Read-domain packet reader: pops fixed-size packets from the async FIFO,
// streams them out with SOP/EOP, and tracks checksum, count and underrun.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_BYTES  = 10,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   R_CLK,
    input  logic                   R_RST,
    input  logic                   EN,
    input  logic                   CLR_ERR,
    fifo_pkt_reader_if.master      bus,
    output logic                   PKT_DONE,
    output logic [DATA_WIDTH-1:0]  PKT_SUM,
    output logic [CNT_WIDTH-1:0]   PKT_CNT,
    output logic                   UNDERRUN_ERR
);
    localparam int IW = $clog2(PKT_BYTES + 1);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(PKT_BYTES - 1);
    localparam logic [SW-1:0] LAST_STALL = SW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SW-1:0]         stall_q, stall_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] psum_q, psum_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic                  err_q, err_d;
    logic                  pop, accept;

    assign accept = valid_q && bus.OUT_READY;
    assign pop    = (state_q == S_STREAM) && !bus.EMPTY
                    && (!valid_q || bus.OUT_READY);

    assign bus.R_INC     = pop;
    assign bus.OUT_DATA  = data_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_SOP   = sop_q;
    assign bus.OUT_EOP   = eop_q;
    assign PKT_DONE      = (state_q == S_DONE);
    assign PKT_SUM       = psum_q;
    assign PKT_CNT       = cnt_q;
    assign UNDERRUN_ERR  = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        sum_d   = sum_q;
        data_d  = data_q;
        psum_d  = psum_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        err_d   = err_q;
        if (CLR_ERR) err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (EN && !bus.EMPTY) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                    sum_d   = '0;
                    stall_d = '0;
                end
            end
            S_STREAM: begin
                if (pop) begin
                    data_d  = bus.RD_DATA;
                    valid_d = 1'b1;
                    sop_d   = (idx_q == '0);
                    eop_d   = (idx_q == LAST_IDX);
                    sum_d   = sum_q + bus.RD_DATA;
                    idx_d   = idx_q + IW'(1);
                    stall_d = '0;
                    if (idx_q == LAST_IDX) state_d = S_DRAIN;
                end else begin
                    if (accept) begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end
                    // starvation only counts once a packet is under way
                    if (bus.EMPTY && idx_q != '0) begin
                        if (stall_q == LAST_STALL) begin
                            err_d   = 1'b1;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                            idx_d   = '0;
                            sum_d   = '0;
                            stall_d = '0;
                            state_d = S_IDLE;
                        end else begin
                            stall_d = stall_q + SW'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    psum_d  = sum_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stall_q <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            psum_q  <= psum_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: queue-based FIFO, packet-level scoreboard
// checked every cycle, plus directed literal expectations per scenario.
module tb_fifo_pkt_reader;
    localparam int DW = 8;
    localparam int PB = 10;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          R_CLK = 1'b0;
    logic          R_RST;
    logic          EN;
    logic          CLR_ERR;
    logic          PKT_DONE;
    logic [DW-1:0] PKT_SUM;
    logic [CW-1:0] PKT_CNT;
    logic          UNDERRUN_ERR;

    fifo_pkt_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_pkt_reader #(
        .DATA_WIDTH(DW), .PKT_BYTES(PB), .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .R_CLK(R_CLK),
        .R_RST(R_RST),
        .EN(EN),
        .CLR_ERR(CLR_ERR),
        .bus(bus),
        .PKT_DONE(PKT_DONE),
        .PKT_SUM(PKT_SUM),
        .PKT_CNT(PKT_CNT),
        .UNDERRUN_ERR(UNDERRUN_ERR)
    );

    always #5 R_CLK = ~R_CLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // ---------------- scoreboard: popped bytes awaiting acceptance
    typedef struct {
        logic [7:0] d;
        int         pos;
    } ent_t;

    ent_t pend[$];
    ent_t e;
    int   m_pidx = 0;
    int   m_stall = 0;
    int   m_sum = 0;
    int   m_last_sum = 0;
    int   m_cnt = 0;
    logic m_err = 1'b0;
    logic m_done_due = 1'b0;
    logic m_abort;

    always @(negedge R_CLK) begin
        if (R_RST) begin
            chk("rst_outs",
                {bus.OUT_VALID, bus.OUT_SOP, bus.OUT_EOP, bus.R_INC,
                 PKT_DONE, UNDERRUN_ERR, bus.OUT_DATA, PKT_SUM, PKT_CNT}, 0);
            pend.delete();
            m_pidx = 0; m_stall = 0; m_sum = 0; m_last_sum = 0;
            m_cnt = 0; m_err = 1'b0; m_done_due = 1'b0;
        end else begin
            chk("pkt_cnt", PKT_CNT, m_cnt);
            chk("underrun", UNDERRUN_ERR, m_err);
            chk("pkt_done", PKT_DONE, m_done_due);
            chk("pkt_sum", PKT_SUM, m_last_sum);
            chk("out_valid", bus.OUT_VALID, pend.size() != 0);
            if (pend.size() != 0) begin
                chk("out_data", bus.OUT_DATA, pend[0].d);
                chk("out_sop", bus.OUT_SOP, pend[0].pos == 0);
                chk("out_eop", bus.OUT_EOP, pend[0].pos == PB - 1);
            end
            if (bus.R_INC)
                chk("rinc_legal", bus.EMPTY || (bus.OUT_VALID && !bus.OUT_READY), 0);
            if (m_pidx > 0)
                chk("rinc_due", bus.R_INC,
                    !bus.EMPTY && (!bus.OUT_VALID || bus.OUT_READY));

            // advance the model across the coming edge
            m_abort = 1'b0;
            if (m_done_due) m_cnt = (m_cnt + 1) % (1 << CW);
            m_done_due = 1'b0;
            if (bus.OUT_VALID && bus.OUT_READY && pend.size() != 0) begin
                e = pend.pop_front();
                m_sum = (m_sum + e.d) % 256;
                if (e.pos == PB - 1) begin
                    m_last_sum = m_sum;
                    m_sum = 0;
                    m_done_due = 1'b1;
                end
            end
            if (bus.R_INC) begin
                pend.push_back('{bus.RD_DATA, m_pidx});
                m_pidx = (m_pidx + 1) % PB;
                m_stall = 0;
            end else if (m_pidx > 0 && bus.EMPTY) begin
                m_stall++;
                if (m_stall == TO) m_abort = 1'b1;
            end
            if (m_abort) begin
                pend.delete();
                m_pidx = 0; m_stall = 0; m_sum = 0;
            end
            if (CLR_ERR) m_err = 1'b0;
            if (m_abort) m_err = 1'b1;
        end
    end

    // ---------------- FIFO and stimulus
    logic [7:0] fifo[$];
    logic [7:0] tmp;
    logic       rdy_pat = 1'b0;
    int cyc = 0, n_pop = 0, n_acc = 0, n_done = 0;
    int run = 0, max_run = 0, eop_cyc = -1, gap = -1;
    int sop_byte = 0, eop_byte = 0, done_sum = 0;

    task automatic drive_fifo();
        bus.EMPTY = (fifo.size() == 0);
        bus.RD_DATA = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic reset_stats();
        n_pop = 0; n_acc = 0; n_done = 0; run = 0; max_run = 0;
        eop_cyc = -1; gap = -1; sop_byte = 0; eop_byte = 0; done_sum = 0;
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) fifo.push_back(8'(i));
        drive_fifo();
    endtask

    task automatic tick();
        logic r, acc;
        @(negedge R_CLK);
        r = bus.R_INC;
        acc = bus.OUT_VALID && bus.OUT_READY;
        if (r) begin
            n_pop++;
            run++;
            if (eop_cyc >= 0 && gap < 0) gap = cyc - eop_cyc - 1;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (acc) begin
            n_acc++;
            if (bus.OUT_SOP) sop_byte = bus.OUT_DATA;
            if (bus.OUT_EOP) begin
                eop_byte = bus.OUT_DATA;
                if (eop_cyc < 0) eop_cyc = cyc;
            end
        end
        if (PKT_DONE) begin
            n_done++;
            done_sum = PKT_SUM;
        end
        @(posedge R_CLK);
        #1;
        if (r) tmp = fifo.pop_front();
        cyc++;
        if (rdy_pat) bus.OUT_READY = (cyc % 3 == 0);
        drive_fifo();
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) tick();
        chk(name, n_done != d0, 1);
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget && fifo.size() != 0; i++) tick();
        chk(name, fifo.size(), 0);
    endtask

    initial begin
        R_RST = 1'b1; EN = 1'b0; CLR_ERR = 1'b0; bus.OUT_READY = 1'b0;
        drive_fifo();
        repeat (3) tick();
        R_RST = 1'b0;
        tick();

        // 1: one packet at full rate
        reset_stats();
        push_range(1, 10);
        EN = 1'b1; bus.OUT_READY = 1'b1;
        wait_done("t1_done", 40);
        chk("t1_run", max_run, 10);
        chk("t1_sum", done_sum, 8'h37);
        chk("t1_sop", sop_byte, 8'h01);
        chk("t1_eop", eop_byte, 8'h0A);
        repeat (3) tick();
        chk("t1_cnt", PKT_CNT, 1);
        chk("t1_ndone", n_done, 1);
        chk("t1_err", UNDERRUN_ERR, 0);

        // 2: ready 1 high / 2 low
        reset_stats();
        push_range(1, 10);
        rdy_pat = 1'b1;
        wait_done("t2_done", 120);
        chk("t2_acc", n_acc, 10);
        chk("t2_sum", done_sum, 8'h37);
        rdy_pat = 1'b0; bus.OUT_READY = 1'b1;
        repeat (2) tick();
        chk("t2_cnt", PKT_CNT, 2);

        // 3: writer pauses mid-packet, below timeout
        reset_stats();
        push_range(1, 4);
        wait_empty("t3_empty", 20);
        repeat (5) tick();
        push_range(5, 10);
        wait_done("t3_done", 40);
        chk("t3_sum", done_sum, 8'h37);
        repeat (2) tick();
        chk("t3_cnt", PKT_CNT, 3);
        chk("t3_err", UNDERRUN_ERR, 0);

        // 4: underrun abort then clear
        reset_stats();
        push_range(1, 4);
        wait_empty("t4_empty", 20);
        repeat (20) tick();
        chk("t4_err", UNDERRUN_ERR, 1);
        chk("t4_valid", bus.OUT_VALID, 0);
        chk("t4_cnt", PKT_CNT, 3);
        chk("t4_ndone", n_done, 0);
        chk("t4_sum", PKT_SUM, 8'h37);
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        chk("t4_clr", UNDERRUN_ERR, 0);

        // 5: back-to-back packets
        reset_stats();
        for (int i = 0; i < 10; i++) fifo.push_back(8'hFF);
        push_range(1, 10);
        wait_done("t5_done1", 40);
        chk("t5_sum1", done_sum, 8'hF6);
        wait_done("t5_done2", 40);
        chk("t5_sum2", done_sum, 8'h37);
        chk("t5_gap", gap, 2);
        repeat (2) tick();
        chk("t5_cnt", PKT_CNT, 5);

        // 6: async reset mid-packet, then EN gating
        reset_stats();
        push_range(1, 10);
        for (int i = 0; i < 20 && n_pop < 5; i++) tick();
        chk("t6_pops", n_pop, 5);
        #2;
        R_RST = 1'b1;
        #1;
        chk("t6_rst_valid", bus.OUT_VALID, 0);
        chk("t6_rst_data", bus.OUT_DATA, 0);
        chk("t6_rst_sop", bus.OUT_SOP, 0);
        chk("t6_rst_rinc", bus.R_INC, 0);
        chk("t6_rst_cnt", PKT_CNT, 0);
        chk("t6_rst_sum", PKT_SUM, 0);
        EN = 1'b0;
        repeat (2) tick();
        R_RST = 1'b0;
        reset_stats();
        repeat (5) tick();
        chk("t6_en_gate", n_pop, 0);
        chk("t6_fifo_left", fifo.size(), 5);
        EN = 1'b1;
        push_range(11, 15);
        wait_done("t6_done", 40);
        chk("t6_sop", sop_byte, 8'h06);
        chk("t6_sum", done_sum, 8'h69);
        repeat (2) tick();
        chk("t6_cnt", PKT_CNT, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
